dsp_sub_simd: RTL

Elastic, pipelined SIMD subtractor: the inverse companion of the DSP adder primitives (`dsp_add`, `dsp_add_v2`, `dsp_add_v4`). It packs `lanes` independent `width`-bit lanes into one 48-bit DSP ALU word and computes per-lane `a - b` with no borrow propagation across lane boundaries. It adds a valid/ready handshake on both sides so datapaths built from the add primitives can stream differences under backpressure.

---
 rtl/dsp_sub_simd.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dsp_sub_simd.sv
// rtl/dsp_sub_simd.sv - elastic two-stage SIMD lane subtractor (optional borrow outputs via DSP_SUB_BORROW_EN)
module dsp_sub_simd #(
    parameter int width = 12,
    parameter int lanes = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [lanes*width-1:0] a,
    input  logic [lanes*width-1:0] b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [lanes*width-1:0] y
`ifdef DSP_SUB_BORROW_EN
    ,
    output logic [lanes-1:0]       borrow
`endif
);

    localparam int W = lanes * width;

    // Only the DSP SIMD packings ONE48/TWO24/FOUR12-style are supported
    generate
        if (!((lanes == 1) || (lanes == 2) || (lanes == 4)) || (width < 1) || (lanes * width > 48)) begin : g_bad_cfg
            $error("dsp_sub_simd: illegal lanes/width combination");
        end
    endgenerate

    // S1: operand registers; S2: result register
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             v1_q, v1_d;
    logic [W-1:0]     y_q, y_d;
    logic             v2_q, v2_d;
    logic [W-1:0]     diff;
    logic             accept;
    logic             advance;
    logic             consume;
`ifdef DSP_SUB_BORROW_EN
    logic [lanes-1:0] borrow_q, borrow_d;
    logic [lanes-1:0] lane_borrow;
`endif

    // Room exists unless both stages are full and the consumer is stalling
    assign in_ready  = reset && (!v1_q || !v2_q || out_ready);
    assign out_valid = v2_q;
    assign y         = y_q;
`ifdef DSP_SUB_BORROW_EN
    assign borrow    = borrow_q;
`endif

    // Per-lane wrap-around difference; lanes are sliced so no borrow crosses a boundary
    always_comb begin
        diff = '0;
`ifdef DSP_SUB_BORROW_EN
        lane_borrow = '0;
`endif
        for (int i = 0; i < lanes; i++) begin
            diff[i*width +: width] = a_q[i*width +: width] - b_q[i*width +: width];
`ifdef DSP_SUB_BORROW_EN
            lane_borrow[i] = a_q[i*width +: width] < b_q[i*width +: width];
`endif
        end
    end

    // Handshake bookkeeping and next-state for both pipeline stages
    always_comb begin
        accept  = in_valid && in_ready;
        advance = v1_q && (!v2_q || out_ready);
        consume = v2_q && out_ready;

        a_d  = a_q;
        b_d  = b_q;
        v1_d = v1_q;
        y_d  = y_q;
        v2_d = v2_q;
`ifdef DSP_SUB_BORROW_EN
        borrow_d = borrow_q;
`endif

        if (accept) begin
            a_d  = a;
            b_d  = b;
            v1_d = 1'b1;
        end else if (advance) begin
            v1_d = 1'b0;
        end

        if (advance) begin
            y_d  = diff;
            v2_d = 1'b1;
`ifdef DSP_SUB_BORROW_EN
            borrow_d = lane_borrow;
`endif
        end else if (consume) begin
            v2_d = 1'b0;
        end
    end

    // State registers; reset discards any in-flight vectors
    always_ff @(posedge clock) begin
        if (!reset) begin
            a_q  <= '0;
            b_q  <= '0;
            v1_q <= 1'b0;
            y_q  <= '0;
            v2_q <= 1'b0;
`ifdef DSP_SUB_BORROW_EN
            borrow_q <= '0;
`endif
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            v1_q <= v1_d;
            y_q  <= y_d;
            v2_q <= v2_d;
`ifdef DSP_SUB_BORROW_EN
            borrow_q <= borrow_d;
`endif
        end
    end

endmodule
